// File: rtl/pc_unit_if.sv
// Fetch/execute bundle of pc_unit: stall, resolve-stage redirects, interrupt
// controls in; pc, pc_plus4, epc, in_isr, flush out. slave = pc_unit side.
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] ex_pc;
    logic             br_en;
    logic             br_cond;
    logic [WIDTH-1:0] br_imm;
    logic             j_en;
    logic [25:0]      j_imm;
    logic             call_en;
    logic             jr_en;
    logic [WIDTH-1:0] jr_target;
    logic             ret_en;
    logic             int_req;
    logic             eret;
    logic [WIDTH-1:0] epc;
    logic             in_isr;
    logic             flush;

    modport master (
        output stall, ex_pc, br_en, br_cond, br_imm, j_en, j_imm,
        output call_en, jr_en, jr_target, ret_en, int_req, eret,
        input  pc, pc_plus4, epc, in_isr, flush
    );

    modport slave (
        input  stall, ex_pc, br_en, br_cond, br_imm, j_en, j_imm,
        input  call_en, jr_en, jr_target, ret_en, int_req, eret,
        output pc, pc_plus4, epc, in_isr, flush
    );
endinterface

// File: rtl/pc_unit.sv
// Registered fetch PC with execute redirects, RUN/PEND/ISR interrupt FSM and EPC.
// Ports: clk, rst_n (async low), bus (pc_unit_if.slave). Optional RAS: PC_RAS_EN.
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] INT_VECTOR   = WIDTH'(32'h0000_0080),
    parameter int               RAS_DEPTH    = 4
) (
    input logic      clk,
    input logic      rst_n,
    pc_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_RUN,
        S_PEND,
        S_ISR
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] ex_pc4;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] j_tgt;
    logic [WIDTH-1:0] jr_tgt;
    logic [WIDTH-1:0] low_nxt;
    logic             br_take;
    logic             int_take;
    logic             eret_take;

    assign pc4       = pc_q + WIDTH'(4);
    assign ex_pc4    = bus.ex_pc + WIDTH'(4);
    assign br_tgt    = ex_pc4 + (bus.br_imm << 2);
    assign j_tgt     = {ex_pc4[WIDTH-1:28], bus.j_imm, 2'b00};
    assign br_take   = bus.br_en & bus.br_cond;
    assign int_take  = (state_q == S_PEND) & ~bus.stall;
    assign eret_take = (state_q == S_ISR) & bus.eret;

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]    sp_q, sp_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             ras_hit;
    logic             push;
    logic             pop;

    // sp_q points at the next free slot; pushing past full wraps onto
    // the oldest entry, which is what makes the stack circular.
    assign ras_hit = bus.jr_en & bus.ret_en & (cnt_q != '0);
    assign jr_tgt  = ras_hit ? ras_q[sp_q - PW'(1)] : bus.jr_target;
    // A discarded jr/j (eret wins) must not touch the stack.
    assign push    = bus.j_en & bus.call_en & ~bus.jr_en & ~eret_take;
    assign pop     = ras_hit & ~eret_take;

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (push) begin
            sp_d  = sp_q + PW'(1);
            cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + (PW+1)'(1);
        end else if (pop) begin
            sp_d  = sp_q - PW'(1);
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) ras_q[sp_q] <= ex_pc4;
    end
`else
    logic unused_ras;

    assign jr_tgt     = bus.jr_target;
    assign unused_ras = ^{bus.call_en, bus.ret_en, RAS_DEPTH[0]};
`endif

    // Choice made when neither the interrupt nor eret wins; also the
    // value saved into epc when an interrupt is taken.
    always_comb begin
        low_nxt = pc_q;
        priority case (1'b1)
            bus.jr_en: low_nxt = jr_tgt;
            bus.j_en:  low_nxt = j_tgt;
            br_take:   low_nxt = br_tgt;
            default:   low_nxt = bus.stall ? pc_q : pc4;
        endcase
    end

    always_comb begin
        pc_d = low_nxt;
        priority case (1'b1)
            int_take:  pc_d = INT_VECTOR;
            eret_take: pc_d = epc_q;
            default:   pc_d = low_nxt;
        endcase
    end

    assign epc_d = int_take ? low_nxt : epc_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN:   if (bus.int_req) state_d = S_PEND;
            S_PEND:  if (!bus.stall) state_d = S_ISR;
            S_ISR:   if (bus.eret) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            state_q <= S_RUN;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            state_q <= state_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc4;
    assign bus.epc      = epc_q;
    assign bus.in_isr   = (state_q == S_ISR);
    assign bus.flush    = int_take | eret_take | bus.jr_en | bus.j_en | br_take;
endmodule

// File: tb/tb_pc_unit.sv
// Randomised and directed bench for pc_unit against a behavioural model.
// Summary: "Result: errors=<n> of <m> checks".
module tb_pc_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] m_pc;
    logic [31:0] m_epc;
    bit          m_isr;
    bit          m_pend;
    logic [31:0] m_ras [$];
    logic [31:0] ret_exp [5];

    always #5 clk = ~clk;

    pc_unit_if #(.WIDTH(W)) bus ();

    pc_unit #(
        .WIDTH(W),
        .RESET_VECTOR(32'h0),
        .INT_VECTOR(32'h80),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        bus.stall     = 1'b0;
        bus.ex_pc     = '0;
        bus.br_en     = 1'b0;
        bus.br_cond   = 1'b0;
        bus.br_imm    = '0;
        bus.j_en      = 1'b0;
        bus.j_imm     = '0;
        bus.call_en   = 1'b0;
        bus.jr_en     = 1'b0;
        bus.jr_target = '0;
        bus.ret_en    = 1'b0;
        bus.int_req   = 1'b0;
        bus.eret      = 1'b0;
    endtask

    task automatic m_reset();
        m_pc   = 32'h0;
        m_epc  = 32'h0;
        m_isr  = 0;
        m_pend = 0;
        m_ras.delete();
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".pc"}, bus.pc, m_pc);
        chk({tag, ".epc"}, bus.epc, m_epc);
        chk({tag, ".isr"}, {31'b0, bus.in_isr}, {31'b0, m_isr});
    endtask

    // Called just after a rising edge; asserts reset between edges.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        chk_regs("async_rst");
        @(posedge clk);
        #1;
        chk_regs("rst_hold");
        rst_n = 1'b1;
    endtask

    // One clock: combinational checks before the edge, registered after.
    task automatic cyc();
        logic [31:0] a4, low, nxt;
        bit it, et, hit, fl, brt;
        @(negedge clk);
        a4  = bus.ex_pc + 32'd4;
        it  = m_pend && !bus.stall;
        et  = m_isr && bus.eret;
        brt = bus.br_en && bus.br_cond;
        hit = 0;
`ifdef PC_RAS_EN
        hit = bus.jr_en && bus.ret_en && (m_ras.size() > 0);
`endif
        if (bus.jr_en)
            low = hit ? m_ras[$] : bus.jr_target;
        else if (bus.j_en)
            low = (a4 & 32'hF000_0000) | ({6'b0, bus.j_imm} * 32'd4);
        else if (brt)
            low = a4 + bus.br_imm * 32'd4;
        else
            low = bus.stall ? m_pc : m_pc + 32'd4;
        nxt = it ? 32'h80 : (et ? m_epc : low);
        fl  = it || et || bus.jr_en || bus.j_en || brt;
        chk("flush", {31'b0, bus.flush}, {31'b0, fl});
        chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        @(posedge clk);
        #1;
        if (!et) begin
`ifdef PC_RAS_EN
            if (bus.j_en && bus.call_en && !bus.jr_en) begin
                m_ras.push_back(a4);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
            if (hit) void'(m_ras.pop_back());
`endif
        end
        if (it) begin
            m_epc  = low;
            m_isr  = 1;
            m_pend = 0;
        end else if (et) begin
            m_isr = 0;
        end else if (!m_isr && !m_pend && bus.int_req) begin
            m_pend = 1;
        end
        m_pc = nxt;
        chk_regs("cyc");
    endtask

    initial begin
`ifdef PC_RAS_EN
        ret_exp = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h4000};
`else
        ret_exp = '{32'h4000, 32'h4000, 32'h4000, 32'h4000, 32'h4000};
`endif
        clr();
        m_reset();
        @(posedge clk);
        #1;
        chk_regs("reset");
        rst_n = 1'b1;

        cyc(); chk("seq4", bus.pc, 32'h4);
        cyc(); chk("seq8", bus.pc, 32'h8);
        cyc(); chk("seqC", bus.pc, 32'hC);
        bus.stall = 1'b1;
        cyc(); cyc();
        chk("stall_hold", bus.pc, 32'hC);

        clr();
        bus.ex_pc   = 32'h100;
        bus.br_en   = 1'b1;
        bus.br_cond = 1'b1;
        bus.br_imm  = -32'sd2;
        cyc(); chk("br_taken", bus.pc, 32'hFC);
        bus.br_cond = 1'b0;
        cyc(); chk("br_not", bus.pc, 32'h100);

        clr();
        bus.stall   = 1'b1;
        bus.int_req = 1'b1;
        cyc(); chk("pend_hold", bus.pc, 32'h100);
        clr();
        bus.j_en  = 1'b1;
        bus.j_imm = 26'h40;
        bus.ex_pc = 32'h200;
        cyc();
        chk("int_pc", bus.pc, 32'h80);
        chk("int_epc", bus.epc, 32'h100);
        chk("int_isr", {31'b0, bus.in_isr}, 32'h1);

        clr();
        bus.int_req = 1'b1;
        cyc(); cyc(); cyc();
        chk("isr_ign", bus.pc, 32'h8C);
        clr();
        bus.eret      = 1'b1;
        bus.jr_en     = 1'b1;
        bus.jr_target = 32'h300;
        cyc();
        chk("eret_pc", bus.pc, 32'h100);
        chk("eret_isr", {31'b0, bus.in_isr}, 32'h0);
        clr();
        bus.eret = 1'b1;
        cyc(); chk("eret_run", bus.pc, 32'h104);

        for (int k = 1; k <= 5; k++) begin
            clr();
            bus.j_en    = 1'b1;
            bus.call_en = 1'b1;
            bus.ex_pc   = 32'(k * 16);
            bus.j_imm   = 26'h200;
            cyc();
        end
        for (int k = 0; k < 5; k++) begin
            clr();
            bus.jr_en     = 1'b1;
            bus.ret_en    = 1'b1;
            bus.jr_target = 32'h4000;
            cyc();
            chk($sformatf("ret%0d", k), bus.pc, ret_exp[k]);
        end

        clr();
        bus.j_en    = 1'b1;
        bus.call_en = 1'b1;
        bus.ex_pc   = 32'h70;
        cyc();
        clr();
        bus.int_req = 1'b1;
        cyc();
        clr();
        cyc();
        chk("isr_before_rst", {31'b0, bus.in_isr}, 32'h1);
        do_reset();
        clr();
        bus.jr_en     = 1'b1;
        bus.ret_en    = 1'b1;
        bus.jr_target = 32'h5000;
        cyc();
        chk("ret_after_rst", bus.pc, 32'h5000);

        for (int i = 0; i < 1500; i++) begin
            int sel;
            clr();
            if (i == 700) do_reset();
            sel           = int'($urandom_range(0, 7));
            bus.stall     = ($urandom_range(0, 3) == 0);
            bus.ex_pc     = $urandom & 32'hFFFF_FFFC;
            bus.br_imm    = $urandom;
            bus.br_cond   = $urandom_range(0, 1) == 1;
            bus.j_imm     = 26'($urandom);
            bus.jr_target = $urandom;
            bus.call_en   = $urandom_range(0, 1) == 1;
            bus.ret_en    = $urandom_range(0, 1) == 1;
            bus.jr_en     = (sel == 0);
            bus.j_en      = (sel == 1);
            bus.br_en     = (sel == 2) || (sel == 3);
            bus.int_req   = ($urandom_range(0, 15) == 0);
            bus.eret      = ($urandom_range(0, 5) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Registered program-counter unit for the pipelined CPU, replacing the combinational next-PC selector. Owns the fetch PC register, resolves branch/jump/jump-register redirects from the execute stage, and runs a three-state interrupt controller with a saved EPC and return-from-interrupt. Parametrised in address width and vectors, with an optional return-address stack. Sits between the fetch stage and the execute-stage redirect logic.

## Interface
Parameters:
- WIDTH, 32, address width; must be ≥ 32
- RESET_VECTOR, 32'h0000_0000, PC after reset
- INT_VECTOR, 32'h0000_0080, interrupt entry point
- RAS_DEPTH, 4, return-address-stack entries (power of 2, ≥ 2); used only with PC_RAS_EN

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold fetch PC
- pc  out  WIDTH  current fetch PC
- pc_plus4  out  WIDTH  pc + 4, combinational
- ex_pc  in  WIDTH  PC of the resolving instruction
- br_en  in  1  branch instruction in execute
- br_cond  in  1  branch condition (ALU zero)
- br_imm  in  WIDTH  sign-extended word offset
- j_en  in  1  J-type jump
- j_imm  in  26  jump word index
- call_en  in  1  jump is a call (link); RAS push
- jr_en  in  1  jump-register
- jr_target  in  WIDTH  register target
- ret_en  in  1  jr is a return; RAS pop
- int_req  in  1  level interrupt request
- eret  in  1  return from interrupt
- epc  out  WIDTH  saved return PC
- in_isr  out  1  interrupt service active
- flush  out  1  squash younger instructions

## Operation
- Targets, modulo 2^WIDTH:
  - branch: ex_pc + 4 + (br_imm << 2)
  - jump: {(ex_pc+4)[WIDTH-1:28], j_imm, 2'b00}
  - jr: jr_target
- Next-PC priority, highest first:
  1. interrupt take: state PEND and stall=0
  2. eret while in ISR
  3. jr_en
  4. j_en
  5. br_en & br_cond
  6. pc_plus4 if stall=0; otherwise hold
- Redirects 2–5 override stall.
- flush is combinational, asserted in any cycle where 1–5 is selected.
- Interrupt FSM:
  - RUN: int_req=1 → PEND.
  - PEND: when stall=0, take: epc ← the next-PC the lower-priority logic would have chosen (redirect target or pc_plus4); pc ← INT_VECTOR; → ISR.
  - ISR: int_req ignored and not latched. eret → pc ← epc, → RUN. Re-entry to PEND requires int_req still high in RUN.
  - eret outside ISR is ignored; it neither redirects nor flushes.
- in_isr = (state == ISR).
- Simultaneous eret and jr/j/br in ISR: eret wins. A redirect arriving in PEND under stall is taken; the interrupt waits.
- Async reset: pc = RESET_VECTOR, epc = 0, state RUN, RAS emptied. Takes effect mid-operation, including mid-ISR and in PEND.

## Timing
- pc is registered; a selected target appears on pc one edge after the request cycle.
- Interrupt latency: int_req high at edge N → PEND at N; taken at the first later edge with stall=0.
- epc and in_isr update on the same edge as the pc redirect.
- pc_plus4 and flush are combinational, with no registered delay.

## Configuration
- PC_RAS_EN defined: RAS_DEPTH-entry circular stack.
  - j_en & call_en: push ex_pc + 4 at the edge.
  - jr_en & ret_en with a non-empty stack: target = top; pop at the edge.
  - Pop on empty: use jr_target; count stays 0.
  - Push when full: overwrite the oldest entry; count saturates at RAS_DEPTH.
  - Push and pop in the same cycle cannot occur, since j_en and jr_en are mutually exclusive.
- PC_RAS_EN undefined: no stack storage; call_en and ret_en are ignored; jr always uses jr_target.

## Test plan
- Reset, then 3 cycles with stall=0 → pc = 0, 4, 8, 0xC; hold stall=1 for 2 cycles → pc stays 0xC; flush=0 throughout.
- ex_pc=0x100, br_en=1, br_cond=1, br_imm=-2 → flush=1, next pc = 0xFC. With br_cond=0 → no flush, pc = pc+4.
- stall=1 with int_req=1 → state PEND, pc held. Release stall while j_en=1, j_imm=0x40, ex_pc=0x200 → pc = 0x80, epc = 0x100, in_isr=1.
- In ISR: int_req=1 is ignored. eret together with jr_en=1 → pc = epc, in_isr=0. eret in RUN → no change.
- PC_RAS_EN, RAS_DEPTH=4: five calls from ex_pc = 0x10, 0x20, … 0x50, then five returns → targets 0x54, 0x44, 0x34, 0x24, then jr_target on the empty pop.
- Deassert rst_n in ISR with RAS non-empty → pc = RESET_VECTOR, in_isr=0, epc=0; the next ret uses jr_target.
